// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM state
// encodings, special scan codes and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    typedef enum logic {
        KT_MAKE  = 1'b0,
        KT_BREAK = 1'b1
    } kt_state_e;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam int         FRAME_BITS = 11;
    // Bits captured after the start bit: 8 data, parity, stop.
    localparam int         SHIFT_BITS = FRAME_BITS - 1;

    // Data plus parity must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Ready/valid scan-code stream between the receiver FIFO and its consumer.
interface ps2_kbd_rx_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and a sticky overflow flag.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty_s, full_s, pop_ok_s, push_ok_s;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop_i & ~empty_s;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push_ok_s = push_i & (~full_s | pop_ok_s);

    // Pointer and overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (push_i & ~push_ok_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o    = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o    = ~empty_s;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, frame deserialiser, scan-code
// FIFO and held-key tracker feeding the seven-segment stage.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 5000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_kbd_rx_if.master        code_if,
    output logic                overflow,
    output logic                frame_err,
    output logic                key_down,
    output logic [7:0]          last_key,
    output logic [3:0]          disp_hi,
    output logic [3:0]          disp_lo,
    output logic [7:0]          press_cnt
);
    localparam int             IW     = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  TO_LIM = IW'(TIMEOUT);
    localparam logic [3:0]     LAST_BIT = 4'(SHIFT_BITS - 1);

    logic                  clk_s1_q, clk_s2_q, clk_hist_q, dat_s1_q, dat_s2_q;
    logic                  fall_s;
    rx_state_e             rx_q, rx_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [SHIFT_BITS-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  err_d, frame_err_q;
    logic                  push_s, frame_ok_s;
    logic [7:0]            rx_byte_s;
    kt_state_e             kt_q, kt_d;
    logic                  key_down_q, key_down_d;
    logic [7:0]            last_key_q, last_key_d, press_cnt_q, press_cnt_d;
    logic [3:0]            disp_hi_q, disp_hi_d, disp_lo_q, disp_lo_d;
    logic [7:0]            code_s;
    logic                  code_valid_s, overflow_s;

    // Pin synchronisers; idle-high reset avoids a false edge on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_s     = clk_hist_q & ~clk_s2_q;
    assign rx_byte_s  = shreg_q[7:0];
    assign frame_ok_s = odd_parity_ok(shreg_q[8:0]) & shreg_q[SHIFT_BITS-1];

    // Receive FSM next-state and idle timer.
    always_comb begin
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        err_d     = 1'b0;
        push_s    = 1'b0;
        if (fall_s || (rx_q != RX_SHIFT)) begin
            idle_d = '0;
        end else if (idle_q < TO_LIM) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = idle_q;
        end
        case (rx_q)
            RX_IDLE: begin
                if (fall_s && !dat_s2_q) begin
                    rx_d      = RX_SHIFT;
                    bit_cnt_d = 4'd0;
                end else if (fall_s) begin
                    err_d = 1'b1;
                end else begin
                    rx_d = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (fall_s) begin
                    shreg_d   = {dat_s2_q, shreg_q[SHIFT_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_d = RX_CHECK;
                    end else begin
                        rx_d = RX_SHIFT;
                    end
                end else if (idle_q >= TO_LIM) begin
                    err_d = 1'b1;
                    rx_d  = RX_IDLE;
                end else begin
                    rx_d = RX_SHIFT;
                end
            end
            RX_CHECK: begin
                push_s = frame_ok_s;
                err_d  = ~frame_ok_s;
                rx_d   = RX_IDLE;
            end
            default: begin
                rx_d = RX_IDLE;
            end
        endcase
    end

    // Receive FSM state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_q        <= RX_IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= '0;
            idle_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            idle_q      <= idle_d;
            frame_err_q <= err_d;
        end
    end

    // Key tracker; typematic repeats of the held key leave press_cnt alone.
    always_comb begin
        kt_d        = kt_q;
        key_down_d  = key_down_q;
        last_key_d  = last_key_q;
        press_cnt_d = press_cnt_q;
        if (!push_s || (rx_byte_s == PS2_EXT)) begin
            kt_d = kt_q;
        end else if (rx_byte_s == PS2_BREAK) begin
            kt_d = KT_BREAK;
        end else begin
            case (kt_q)
                KT_BREAK: begin
                    if (rx_byte_s == last_key_q) begin
                        key_down_d = 1'b0;
                    end else begin
                        key_down_d = key_down_q;
                    end
                    kt_d = KT_MAKE;
                end
                KT_MAKE: begin
                    if (!key_down_q || (rx_byte_s != last_key_q)) begin
                        press_cnt_d = press_cnt_q + 8'd1;
                    end else begin
                        press_cnt_d = press_cnt_q;
                    end
                    last_key_d = rx_byte_s;
                    key_down_d = 1'b1;
                end
                default: begin
                    kt_d = KT_MAKE;
                end
            endcase
        end
        if (key_down_d) begin
            disp_hi_d = last_key_d[7:4];
            disp_lo_d = last_key_d[3:0];
        end else begin
            disp_hi_d = 4'h0;
            disp_lo_d = 4'h0;
        end
    end

    // Key tracker registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kt_q        <= KT_MAKE;
            key_down_q  <= 1'b0;
            last_key_q  <= 8'h00;
            press_cnt_q <= 8'h00;
            disp_hi_q   <= 4'h0;
            disp_lo_q   <= 4'h0;
        end else begin
            kt_q        <= kt_d;
            key_down_q  <= key_down_d;
            last_key_q  <= last_key_d;
            press_cnt_q <= press_cnt_d;
            disp_hi_q   <= disp_hi_d;
            disp_lo_q   <= disp_lo_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_s),
        .wdata_i    (rx_byte_s),
        .pop_i      (code_if.code_ready),
        .rdata_o    (code_s),
        .valid_o    (code_valid_s),
        .overflow_o (overflow_s)
    );

    assign code_if.code       = code_s;
    assign code_if.code_valid = code_valid_s;
    assign overflow           = overflow_s;
    assign frame_err          = frame_err_q;
    assign key_down           = key_down_q;
    assign last_key           = last_key_q;
    assign disp_hi            = disp_hi_q;
    assign disp_lo            = disp_lo_q;
    assign press_cnt          = press_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed and randomized frames against a byte-level reference model of the
// scan-code queue and held-key rules.
module tb_ps2_kbd_rx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       overflow, frame_err, key_down;
    logic [7:0] last_key, press_cnt;
    logic [3:0] disp_hi, disp_lo;

    ps2_kbd_rx_if code_if ();

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_if   (code_if),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_down  (key_down),
        .last_key  (last_key),
        .disp_hi   (disp_hi),
        .disp_lo   (disp_lo),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    // Reference model: expected queue contents and held-key state.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_held = 1'b0, m_brk = 1'b0;
    logic [7:0] m_last = 8'h00, m_cnt = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_held = 1'b0; m_brk = 1'b0; m_last = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
        if (b == 8'hE0) begin
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            if (b == m_last) m_held = 1'b0;
            m_brk = 1'b0;
        end else begin
            if (!m_held || b != m_last) m_cnt = m_cnt + 8'd1;
            m_last = b;
            m_held = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_raw(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = fr[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int e0;
        e0 = err_cnt;
        send_raw(mk_frame(b, bad_par, bad_stop), 11);
        repeat (20) @(negedge clk);
        chk("frame_err_pulses", err_cnt - e0, (bad_par || bad_stop) ? 1 : 0);
        if (!bad_par && !bad_stop) model_accept(b);
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        chk({tag, "_key_down"},   key_down, m_held);
        chk({tag, "_last_key"},   last_key, m_last);
        chk({tag, "_disp_hi"},    disp_hi, m_held ? m_last[7:4] : 4'h0);
        chk({tag, "_disp_lo"},    disp_lo, m_held ? m_last[3:0] : 4'h0);
        chk({tag, "_press_cnt"},  press_cnt, m_cnt);
        chk({tag, "_overflow"},   overflow, m_ovf);
        chk({tag, "_code_valid"}, code_if.code_valid, q.size() > 0);
        chk({tag, "_code"},       code_if.code, head);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            @(negedge clk);
            chk({tag, "_pop_valid"}, code_if.code_valid, 1'b1);
            chk({tag, "_pop_code"},  code_if.code, q[0]);
            void'(q.pop_front());
            code_if.code_ready = 1'b1;
        end
        @(negedge clk);
        code_if.code_ready = 1'b0;
        chk({tag, "_empty_after"}, code_if.code_valid, 1'b0);
    endtask

    initial begin
        logic [10:0] ones;
        logic [7:0]  b;
        int          e0, sel;
        logic        bad;
        ones = 11'h7FF;
        code_if.code_ready = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_all("reset");
        chk("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_byte(8'h1C, 1'b0, 1'b0);
        check_all("make_1c");
        send_byte(8'h1C, 1'b0, 1'b0);
        check_all("repeat_1c");
        send_byte(8'hF0, 1'b0, 1'b0);
        check_all("break_f0");
        send_byte(8'h1C, 1'b0, 1'b0);
        check_all("release_1c");
        drain("seq");

        send_byte(8'h32, 1'b1, 1'b0);
        check_all("bad_parity");
        send_byte(8'h32, 1'b0, 1'b1);
        check_all("bad_stop");

        e0 = err_cnt;
        send_raw(ones, 1);
        repeat (20) @(negedge clk);
        chk("bad_start_pulses", err_cnt - e0, 1);

        e0 = err_cnt;
        send_raw(mk_frame(8'h45, 1'b0, 1'b0), 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        chk("timeout_pulses", err_cnt - e0, 1);
        check_all("after_timeout");
        send_byte(8'h45, 1'b0, 1'b0);
        check_all("after_timeout_45");
        drain("timeout");

        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_all("overflow");
        chk("overflow_set", overflow, 1'b1);
        drain("overflow");

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: b = m_last;
                3: b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 4) == 0);
            send_byte(b, bad, 1'b0);
            check_all("random");
            if (q.size() == DEPTH) drain("random_full");
        end
        drain("random");

        send_byte(8'h29, 1'b0, 1'b0);
        e0 = err_cnt;
        send_raw(mk_frame(8'h33, 1'b0, 1'b0), 5);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check_all("mid_reset");
        chk("mid_reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send_byte(8'h5A, 1'b0, 1'b0);
        chk("post_reset_no_err", err_cnt - e0, 0);
        check_all("post_reset_5a");
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
